muldiv_arbiter: RTL and testbench
=================================

# muldiv_arbiter

Two-port arbiter and sequencer for the shared signed multiply/divide unit (`divider`, operands `opera1[31:0]`/`opera2[63:0]`, mode `muordi`, `start`, `valid`, `result[63:0]`). It accepts operation requests from two independent requesters and grants them round-robin. For each granted request it latches the operands, drives the unit's start sequence and waits for the unit's `valid`. It then returns the 64-bit result, or a timeout error, to the winning requester.

## Interface
- `START_CYCLES`, default 2: number of cycles `unit_start` is held high per operation (≥1).
- `TIMEOUT`, default 4095: maximum cycles spent waiting for `unit_valid` before aborting (≥1). Counter width is `$clog2(TIMEOUT+1)`.

- `clock`  in  1  — sole clock, rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `req0`, `req1`  in  1 each  — operation request, held high until the matching `done` pulse.
- `md0`, `md1`  in  1 each  — mode: 0 = multiply, 1 = divide (maps to `muordi`).
- `a0`, `a1`  in  32 each  — signed operand to `opera1` (multiplier / divisor).
- `b0`, `b1`  in  64 each  — signed operand to `opera2` (multiplicand / dividend).
- `done0`, `done1`  out  1 each  — one-cycle completion pulse to the granted requester.
- `rsp_result`  out  64  — result of the last completed operation. For divide: `[63:32]` = remainder, `[31:0]` = quotient.
- `rsp_err`  out  1  — 1 if the last completed operation timed out.
- `busy`  out  1  — high in any state except IDLE.
- `unit_start`  out  1  — start to the unit.
- `unit_muordi`  out  1  — mode to the unit.
- `unit_opera1`  out  32  — operand to the unit.
- `unit_opera2`  out  64  — operand to the unit.
- `unit_result`  in  64  — unit result.
- `unit_valid`  in  1  — unit result valid (level).

## Operation
- States: IDLE, START, WAIT, DONE.
- **Reset.** All outputs are 0, state is IDLE, round-robin pointer `last` = 1 (so port 0 wins first), counters are 0, operand registers are 0. Reset acts immediately (asynchronously), including mid-operation; any in-flight operation is dropped with no `done` pulse.
- **IDLE.**
  - If exactly one `req` is high, grant it.
  - If both are high, grant the port ≠ `last`.
  - On grant: latch `md`/`a`/`b` of the winner into the operand registers, record the winner in `gnt`, set `last` = winner, go to START.
- **START.**
  - `unit_start` = 1 for exactly `START_CYCLES` cycles.
  - `unit_muordi`/`unit_opera1`/`unit_opera2` come from the latched registers. They stay stable from START entry until DONE exit.
  - Then go to WAIT with the timeout counter cleared.
- **WAIT.**
  - `unit_start` = 0.
  - Completion is a rising edge of `unit_valid`, detected against a registered copy that is cleared on START entry. A level left over from a previous operation is therefore never accepted.
  - On that edge: capture `unit_result` into `rsp_result`, set `rsp_err` = 0, go to DONE.
  - Else, if the counter equals `TIMEOUT`: set `rsp_result` = 0 and `rsp_err` = 1, go to DONE.
  - Otherwise increment the counter.
  - If the edge and the timeout happen in the same cycle, the valid edge wins.
- **DONE.** `done[gnt]` = 1 for one cycle, then go to IDLE.
- `rsp_result`/`rsp_err` hold their values until the next DONE entry.
- **Request withdrawn after grant.** The operation still completes and `done` still pulses.
- **Request withdrawn before grant.** No effect.
- **Input changes after grant.** Changes on `a`/`b`/`md` have no effect on the current operation.
- **Arithmetic.** The controller performs none; results pass through bit-exact.

## Timing
- Request sampled high in IDLE at edge k:
  - START is entered at k+1.
  - `unit_start` is high for cycles k+1 … k+`START_CYCLES`.
  - WAIT is entered at k+`START_CYCLES`+1.
- A `unit_valid` rising edge seen at edge m in WAIT gives DONE, `done` high, and `rsp_result` valid from m+1 for one cycle.
- Timeout: DONE is reached `TIMEOUT`+1 cycles after WAIT entry.
- Back-to-back: IDLE lasts at least 1 cycle between operations. With both ports requesting continuously, grants alternate 0,1,0,1…

## Test plan
- **Single multiply.** `req0`, `md0`=0, `a0`=2, `b0`=7; unit model asserts valid 10 cycles into WAIT with 14. Required: `unit_start` high for 2 cycles, `done0` pulse, `rsp_result`=14, `rsp_err`=0, `done1` never pulses.
- **Signed divides on port 1.** a=2 with b=7, −7, and a=−2 with b=7, −7; model returns truncating quotient/remainder. Required: `rsp_result` = {1,3}, {−1,−3}, {1,−3}, {−1,3}; ignoring an already-high `unit_valid` at START entry.
- **Arbitration.** `req0`=`req1`=1 from reset release, held. Required: grant order 0,1,0,1; each operation's `unit_opera1`/`unit_opera2` matches its own port. Port-1 input changes during a port-0 operation do not disturb `unit_opera*`.
- **Timeout.** `TIMEOUT`=16, model never asserts valid. Required: `done0` exactly 17 cycles after WAIT entry, `rsp_err`=1, `rsp_result`=0. The next normal operation clears `rsp_err`.
- **Reset mid-WAIT.** `reset`=0 asserted asynchronously during WAIT. Required: all outputs go to 0 before the next clock edge, with no `done` pulse. After release, the still-high `req0` restarts from START with freshly latched operands.
- **Withdrawal.** `req1` drops 3 cycles after grant. Required: the operation completes and `done1` pulses; a request dropped before grant is never served.

Source files
------------

// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter and sequencer that shares one multiply/divide unit between two requesters.
// Grant to done is START_CYCLES + wait + 2 cycles; requesters are held off by keeping done low.
module muldiv_arbiter #(
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 4095
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        md0,
  input  logic        md1,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [63:0] b0,
  input  logic [63:0] b1,
  output logic        done0,
  output logic        done1,
  output logic [63:0] rsp_result,
  output logic        rsp_err,
  output logic        busy,
  output logic        unit_start,
  output logic        unit_muordi,
  output logic [31:0] unit_opera1,
  output logic [63:0] unit_opera2,
  input  logic [63:0] unit_result,
  input  logic        unit_valid
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SW-1:0] SLAST = SW'(START_CYCLES - 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t        state, state_nx;
  logic          last;
  logic          gnt;
  logic          vld_q;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic          take;
  logic          win;
  logic          vld_edge;

  // Only a fresh rising edge counts; vld_q is cleared at grant so a stale level is absorbed during START.
  assign vld_edge = unit_valid & ~vld_q;

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    win      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          take = 1'b1;
          win  = ~last;
        end else if (req0) begin
          take = 1'b1;
          win  = 1'b0;
        end else if (req1) begin
          take = 1'b1;
          win  = 1'b1;
        end
        if (take) state_nx = START;
      end
      START:   if (scnt == SLAST) state_nx = WAIT;
      WAIT:    if (vld_edge || (tcnt == TMAX)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last        <= 1'b1;
      gnt         <= 1'b0;
      vld_q       <= 1'b0;
      scnt        <= '0;
      tcnt        <= '0;
      unit_muordi <= 1'b0;
      unit_opera1 <= '0;
      unit_opera2 <= '0;
      rsp_result  <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state <= state_nx;
      vld_q <= take ? 1'b0 : unit_valid;
      scnt  <= (state == START && state_nx == START) ? scnt + SW'(1) : '0;
      tcnt  <= (state == WAIT && state_nx == WAIT) ? tcnt + TW'(1) : '0;
      if (take) begin
        gnt         <= win;
        last        <= win;
        unit_muordi <= win ? md1 : md0;
        unit_opera1 <= win ? a1 : a0;
        unit_opera2 <= win ? b1 : b0;
      end
      // A valid edge in the same cycle as the timeout still delivers the result.
      if (state == WAIT && state_nx == DONE) begin
        if (vld_edge) begin
          rsp_result <= unit_result;
          rsp_err    <= 1'b0;
        end else begin
          rsp_result <= '0;
          rsp_err    <= 1'b1;
        end
      end
    end
  end

  assign busy       = (state != IDLE);
  assign unit_start = (state == START);
  assign done0      = (state == DONE) && !gnt;
  assign done1      = (state == DONE) && gnt;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed bench for muldiv_arbiter with a behavioural multiply/divide unit model.
module tb_muldiv_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, md0 = 1'b0, md1 = 1'b0;
  logic [31:0] a0 = '0, a1 = '0;
  logic [63:0] b0 = '0, b1 = '0;
  logic        done0, done1, rsp_err, busy, unit_start, unit_muordi;
  logic [63:0] rsp_result, unit_opera2;
  logic [31:0] unit_opera1;
  logic [63:0] unit_result = '0;
  logic        unit_valid = 1'b0;

  int errors = 0;
  int checks = 0;

  // unit model knobs
  int  delay = 10;
  bit  never = 1'b0;
  int  mcnt  = 0;
  bit  mact  = 1'b0;
  logic signed [63:0] m_q, m_r, m_a;

  bit seen_s, inw;
  int nd, nb;

  muldiv_arbiter #(.START_CYCLES(2), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .md0(md0), .md1(md1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .done0(done0), .done1(done1),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
    .unit_start(unit_start), .unit_muordi(unit_muordi),
    .unit_opera1(unit_opera1), .unit_opera2(unit_opera2),
    .unit_result(unit_result), .unit_valid(unit_valid)
  );

  always #5 clock = ~clock;

  // Unit model: keeps valid high from the previous op until one cycle into WAIT, then drops it.
  always @(negedge clock) begin
    if (!reset) begin
      mcnt = 0; mact = 1'b0; unit_valid = 1'b0; unit_result = '0;
    end else if (unit_start) begin
      mact = 1'b1; mcnt = 0;
    end else if (mact) begin
      mcnt++;
      if (mcnt == 1) unit_valid = 1'b0;
      if (!never && mcnt == delay) begin
        m_a = $signed({{32{unit_opera1[31]}}, unit_opera1});
        if (unit_muordi) begin
          m_q = $signed(unit_opera2) / m_a;
          m_r = $signed(unit_opera2) % m_a;
          unit_result = {m_r[31:0], m_q[31:0]};
        end else begin
          unit_result = $signed(unit_opera2) * m_a;
        end
        unit_valid = 1'b1;
        mact = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Follows one operation to its done pulse. kind 1: disturb port-1 inputs at cycle ev;
  // kind 2: raise req0 at cycle 0 and withdraw both requests at cycle ev.
  task automatic wait_done(input string tag, input int port, input logic md,
                           input logic [31:0] a, input logic [63:0] b,
                           input logic [63:0] res, input logic err, input int wexp,
                           input int kind, input int ev, input bit hold);
    int wcyc = 0, nstart = 0, bad = 0, other = 0;
    bit got = 1'b0, seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (kind == 1 && i == ev) begin a1 = 32'd11; b1 = 64'd13; md1 = 1'b1; end
      if (kind == 2 && i == 0) req0 = 1'b1;
      if (kind == 2 && i == ev) begin req0 = 1'b0; req1 = 1'b0; end
      if (unit_start) begin nstart++; seen = 1'b1; end
      if (seen && busy && ({unit_muordi, unit_opera1, unit_opera2} !== {md, a, b})) bad++;
      if ((port == 0) ? done1 : done0) other++;
      if ((port == 0) ? done0 : done1) begin
        got = 1'b1;
        if (!hold) begin req0 = 1'b0; req1 = 1'b0; end
        break;
      end
      if (seen && busy && !unit_start) wcyc++;
    end
    chk({tag, " done"}, 64'(got), 64'd1);
    chk({tag, " other_done"}, 64'(other), 64'd0);
    chk({tag, " start_cycles"}, 64'(nstart), 64'd2);
    chk({tag, " wait_cycles"}, 64'(wcyc), 64'(wexp));
    chk({tag, " operands"}, 64'(bad), 64'd0);
    chk({tag, " result"}, rsp_result, res);
    chk({tag, " err"}, 64'(rsp_err), 64'(err));
    @(negedge clock);
    chk({tag, " idle_after"}, {61'd0, busy, done0, done1}, 64'd0);
    chk({tag, " result_hold"}, rsp_result, res);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst busy/done/start", {60'd0, busy, done0, done1, unit_start}, 64'd0);
    chk("rst opera2", unit_opera2, 64'd0);
    chk("rst opera1/muordi", {31'd0, unit_muordi, unit_opera1}, 64'd0);
    chk("rst rsp", {rsp_err, rsp_result[62:0]} | {63'd0, rsp_result[63]}, 64'd0);
    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle no req", 64'(busy), 64'd0);

    // single multiply on port 0
    md0 = 1'b0; a0 = 32'd2; b0 = 64'd7; req0 = 1'b1; delay = 10;
    wait_done("mul", 0, 1'b0, 32'd2, 64'd7, 64'd14, 1'b0, 10, 0, 0, 1'b0);

    // signed divides on port 1; valid is still high from the previous op at each START entry
    md1 = 1'b1; a1 = 32'd2; b1 = 64'd7; req1 = 1'b1;
    wait_done("div +2,+7", 1, 1'b1, 32'd2, 64'd7, 64'h00000001_00000003, 1'b0, 10, 0, 0, 1'b0);
    md1 = 1'b1; a1 = 32'd2; b1 = 64'hFFFFFFFF_FFFFFFF9; req1 = 1'b1;
    wait_done("div +2,-7", 1, 1'b1, 32'd2, 64'hFFFFFFFF_FFFFFFF9, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 10, 0, 0, 1'b0);
    md1 = 1'b1; a1 = 32'hFFFFFFFE; b1 = 64'd7; req1 = 1'b1;
    wait_done("div -2,+7", 1, 1'b1, 32'hFFFFFFFE, 64'd7, 64'h00000001_FFFFFFFD, 1'b0, 10, 0, 0, 1'b0);
    md1 = 1'b1; a1 = 32'hFFFFFFFE; b1 = 64'hFFFFFFFF_FFFFFFF9; req1 = 1'b1;
    wait_done("div -2,-7", 1, 1'b1, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFF9, 64'hFFFFFFFF_00000003, 1'b0, 10, 0, 0, 1'b0);

    // timeout, then a normal op clears the error
    never = 1'b1; md0 = 1'b0; a0 = 32'd1; b0 = 64'd1; req0 = 1'b1;
    wait_done("timeout", 0, 1'b0, 32'd1, 64'd1, 64'd0, 1'b1, 17, 0, 0, 1'b0);
    never = 1'b0; a0 = 32'd3; b0 = 64'd3; req0 = 1'b1;
    wait_done("after tmo", 0, 1'b0, 32'd3, 64'd3, 64'd9, 1'b0, 10, 0, 0, 1'b0);

    // asynchronous reset in the middle of WAIT
    a0 = 32'd5; b0 = 64'd6; req0 = 1'b1;
    seen_s = 1'b0; inw = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (unit_start) seen_s = 1'b1;
      else if (seen_s && busy) begin inw = 1'b1; break; end
    end
    chk("rst reach wait", 64'(inw), 64'd1);
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst ctl", {60'd0, busy, done0, done1, unit_start}, 64'd0);
    chk("arst opera2", unit_opera2, 64'd0);
    chk("arst opera1/muordi", {31'd0, unit_muordi, unit_opera1}, 64'd0);
    chk("arst rsp_result", rsp_result, 64'd0);
    chk("arst rsp_err", 64'(rsp_err), 64'd0);
    a0 = 32'd7; b0 = 64'd8;
    nd = 0; nb = 0;
    repeat (3) begin
      @(negedge clock);
      if (done0 || done1) nd++;
      if (busy) nb++;
    end
    chk("arst no done/busy", 64'(nd + nb), 64'd0);
    reset = 1'b1;
    wait_done("restart", 0, 1'b0, 32'd7, 64'd8, 64'd56, 1'b0, 10, 0, 0, 1'b0);

    // arbitration from reset release with both ports requesting
    reset = 1'b0;
    md0 = 1'b0; a0 = 32'd3; b0 = 64'd5;
    md1 = 1'b0; a1 = 32'd4; b1 = 64'd6;
    req0 = 1'b1; req1 = 1'b1; delay = 3;
    @(negedge clock); reset = 1'b1;
    wait_done("arb op1 p0", 0, 1'b0, 32'd3, 64'd5, 64'd15, 1'b0, 3, 1, 3, 1'b1);
    wait_done("arb op2 p1", 1, 1'b1, 32'd11, 64'd13, 64'h00000002_00000001, 1'b0, 3, 0, 0, 1'b1);
    wait_done("arb op3 p0", 0, 1'b0, 32'd3, 64'd5, 64'd15, 1'b0, 3, 0, 0, 1'b1);
    wait_done("arb op4 p1", 1, 1'b1, 32'd11, 64'd13, 64'h00000002_00000001, 1'b0, 3, 0, 0, 1'b0);

    // withdrawal after grant completes; a request dropped before grant is never served
    delay = 4; md1 = 1'b0; a1 = 32'd3; b1 = 64'd4; req1 = 1'b1;
    wait_done("withdraw", 1, 1'b0, 32'd3, 64'd4, 64'd12, 1'b0, 4, 2, 3, 1'b0);
    nd = 0; nb = 0;
    repeat (20) begin
      @(negedge clock);
      if (done0 || done1) nd++;
      if (busy) nb++;
    end
    chk("dropped req not served", 64'(nd + nb), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
